// File: rtl/pong_ball_ctrl.sv
// Ping-pong game controller: moves a one-hot ball across 8 LEDs, judges
// paddle returns and misses, keeps score and drives the LED register.
module pong_ball_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [7:0] disp_data,
  output logic       disp_ld,
  output logic       disp_clr,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int unsigned     CntW     = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [3:0]      WinScore = 4'(WIN_SCORE);

  // Player encoding for server/scorer.
  localparam logic Left  = 1'b0;
  localparam logic Right = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StMoveR,
    StMoveL,
    StPoint,
    StOver
  } state_e;

  state_e          state_q;
  logic [7:0]      pos_q;
  logic            server_q;
  logic            scorer_q;
  logic [CntW-1:0] cnt_q;
  logic            start_q;
  logic            btn_l_q;
  logic            btn_r_q;

  logic       start_press;
  logic       press_l;
  logic       press_r;
  logic       tick;
  logic [3:0] new_score;

  // Press detection, step tick and the score the current POINT would produce.
  always_comb begin
    start_press = start & ~start_q;
    press_l     = btn_l & ~btn_l_q;
    press_r     = btn_r & ~btn_r_q;
    tick        = (cnt_q == CntMax);
    new_score   = ((scorer_q == Left) ? score_l : score_r) + 4'd1;
  end

  assign disp_data = pos_q;

  // Game FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      pos_q     <= 8'h00;
      server_q  <= Left;
      scorer_q  <= Left;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      btn_l_q   <= 1'b0;
      btn_r_q   <= 1'b0;
      disp_ld   <= 1'b0;
      disp_clr  <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
    end else begin
      start_q <= start;
      btn_l_q <= btn_l;
      btn_r_q <= btn_r;
      disp_ld <= 1'b0;
      // Counter only advances in the MOVE states; every transition restarts it.
      cnt_q   <= '0;

      case (state_q)
        StIdle: begin
          if (start_press) begin
            score_l  <= 4'd0;
            score_r  <= 4'd0;
            server_q <= Left;
            pos_q    <= 8'h80;
            disp_ld  <= 1'b1;
            disp_clr <= 1'b0;
            state_q  <= StServe;
          end
        end

        StServe: begin
          if ((server_q == Left) && press_l) begin
            state_q <= StMoveR;
          end else if ((server_q == Right) && press_r) begin
            state_q <= StMoveL;
          end
        end

        StMoveR: begin
          // A swing outranks the tick, so a return on the tick cycle still counts.
          if (press_r) begin
            if (pos_q == 8'h01) begin
              state_q <= StMoveL;
            end else begin
              scorer_q <= Left;
              state_q  <= StPoint;
            end
          end else if (tick) begin
            if (pos_q == 8'h01) begin
              scorer_q <= Left;
              state_q  <= StPoint;
            end else begin
              pos_q   <= pos_q >> 1;
              disp_ld <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StMoveL: begin
          if (press_l) begin
            if (pos_q == 8'h80) begin
              state_q <= StMoveR;
            end else begin
              scorer_q <= Right;
              state_q  <= StPoint;
            end
          end else if (tick) begin
            if (pos_q == 8'h80) begin
              scorer_q <= Right;
              state_q  <= StPoint;
            end else begin
              pos_q   <= pos_q << 1;
              disp_ld <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StPoint: begin
          if (scorer_q == Left) begin
            score_l <= new_score;
          end else begin
            score_r <= new_score;
          end
          // The player who conceded serves next.
          server_q <= ~scorer_q;
          disp_ld  <= 1'b1;
          if (new_score == WinScore) begin
            pos_q     <= 8'hFF;
            game_over <= 1'b1;
            state_q   <= StOver;
          end else begin
            pos_q   <= (scorer_q == Left) ? 8'h01 : 8'h80;
            state_q <= StServe;
          end
        end

        StOver: begin
          if (start_press) begin
            game_over <= 1'b0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            server_q  <= Left;
            pos_q     <= 8'h80;
            disp_ld   <= 1'b1;
            state_q   <= StServe;
          end
        end

        default: begin
          state_q  <= StIdle;
          pos_q    <= 8'h00;
          disp_clr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: a per-cycle vector table for the opening
// serve and miss, then hand-written sequences for rallies, holds and game over.
module tb_pong_ball_ctrl;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic       btn_l;
  logic       btn_r;
  logic [7:0] disp_data;
  logic       disp_ld;
  logic       disp_clr;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  pong_ball_ctrl #(
    .TICK_DIV (4),
    .WIN_SCORE(7)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .disp_data(disp_data),
    .disp_ld  (disp_ld),
    .disp_clr (disp_clr),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr_n;
    logic       start;
    logic       bl;
    logic       br;
    logic [7:0] data;
    logic       ld;
    logic       clr;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, s, l, r, input logic [7:0] d, input logic ld, clr,
                     input logic [3:0] sl, sr, input logic go);
    vec_t v;
    v.clr_n = c; v.start = s; v.bl = l; v.br = r;
    v.data = d; v.ld = ld; v.clr = clr; v.sl = sl; v.sr = sr; v.go = go;
    vecs.push_back(v);
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic c, s, l, r);
    clr_n = c; start = s; btn_l = l; btn_r = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] d, input logic ld, clr,
                       input logic [3:0] sl, sr, input logic go);
    n_checks++;
    if (disp_data !== d || disp_ld !== ld || disp_clr !== clr || score_l !== sl ||
        score_r !== sr || game_over !== go) begin
      n_fail++;
      $display("FAIL %s: got data=%h ld=%b clr=%b sl=%0d sr=%0d go=%b, want data=%h ld=%b clr=%b sl=%0d sr=%0d go=%b",
               name, disp_data, disp_ld, disp_clr, score_l, score_r, game_over,
               d, ld, clr, sl, sr, go);
    end
  endtask

  // One ball step: three quiet cycles, then the tick moves the ball.
  task automatic step(input logic [7:0] prev, nxt, input logic [3:0] sl, sr);
    repeat (3) drive(1, 0, 0, 0);
    check("step_hold", prev, 0, 0, sl, sr, 0);
    drive(1, 0, 0, 0);
    check("step_move", nxt, 1, 0, sl, sr, 0);
  endtask

  // Right serves, left returns at bit7, right swings early: point to left.
  task automatic left_point(input logic [3:0] sl, sr, input logic last);
    drive(1, 0, 0, 1);
    repeat (28) drive(1, 0, 0, 0);
    check("lp_at_left", 8'h80, 1, 0, sl - 4'd1, sr, 0);
    drive(1, 0, 1, 0);
    check("lp_return", 8'h80, 0, 0, sl - 4'd1, sr, 0);
    drive(1, 0, 0, 1);
    check("lp_point", 8'h80, 0, 0, sl - 4'd1, sr, 0);
    drive(1, 0, 0, 0);
    if (last) check("lp_over", 8'hFF, 1, 0, sl, sr, 1);
    else      check("lp_serve", 8'h01, 1, 0, sl, sr, 0);
  endtask

  initial begin
    logic [7:0] p;
    clr_n = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;

    // Reset, idle, start, serve, then an unanswered run to the right end.
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 8'h80, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 8'h80, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 8'h80, 0, 0, 0, 0, 0);
    p = 8'h80;
    for (int s = 1; s <= 7; s++) begin
      // btn_l pulses during MOVE_R must be ignored.
      add(1, 0, 1, 0, p, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, p, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, p, 0, 0, 0, 0, 0);
      p = p >> 1;
      add(1, 0, 0, 0, p, 1, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h01, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 8'h01, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 8'h01, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr_n, vecs[i].start, vecs[i].bl, vecs[i].br);
      check($sformatf("vec%0d", i), vecs[i].data, vecs[i].ld, vecs[i].clr,
            vecs[i].sl, vecs[i].sr, vecs[i].go);
    end

    // Ball travels left; left returns on the tick cycle at bit7.
    p = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      step(p, p << 1, 1, 0);
      p = p << 1;
    end
    repeat (3) drive(1, 0, 0, 0);
    drive(1, 0, 1, 0);
    check("ret_l_on_tick", 8'h80, 0, 0, 1, 0, 0);
    step(8'h80, 8'h40, 1, 0);
    p = 8'h40;
    for (int k = 2; k <= 7; k++) begin
      step(p, p >> 1, 1, 0);
      p = p >> 1;
    end

    // Right returns on the tick cycle at bit0: return wins, pos holds.
    repeat (3) drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    check("ret_r_on_tick", 8'h01, 0, 0, 1, 0, 0);
    step(8'h01, 8'h02, 1, 0);
    step(8'h02, 8'h04, 1, 0);

    // btn_r is ignored in MOVE_L and does not disturb the step timing.
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("btn_r_ignored", 8'h08, 1, 0, 1, 0, 0);

    // Early left swing at 08: point to right, left serves from bit7.
    drive(1, 0, 1, 0);
    check("early_l_point", 8'h08, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0);
    check("early_l_serve", 8'h80, 1, 0, 1, 1, 0);

    // Left serves, ball reaches 04, right swings early and holds the button.
    drive(1, 0, 1, 0);
    check("serve_l", 8'h80, 0, 0, 1, 1, 0);
    p = 8'h80;
    for (int k = 1; k <= 5; k++) begin
      step(p, p >> 1, 1, 1);
      p = p >> 1;
    end
    drive(1, 0, 0, 1);
    check("early_r_point", 8'h04, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1);
    check("early_r_serve", 8'h01, 1, 0, 2, 1, 0);
    repeat (19) drive(1, 0, 0, 1);
    check("held_btn_r", 8'h01, 0, 0, 2, 1, 0);
    drive(1, 0, 0, 0);

    // Left runs the score to seven.
    left_point(3, 1, 0);
    left_point(4, 1, 0);
    left_point(5, 1, 0);
    left_point(6, 1, 0);
    left_point(7, 1, 1);
    drive(1, 0, 0, 0);
    check("over_hold", 8'hFF, 0, 0, 7, 1, 1);
    drive(1, 0, 1, 1);
    check("over_btns_ignored", 8'hFF, 0, 0, 7, 1, 1);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    check("restart", 8'h80, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0);

    // Earn a point, start a rally and reset it with the ball at 10.
    drive(1, 0, 1, 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    check("rs_point", 8'h01, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 1);
    repeat (16) drive(1, 0, 0, 0);
    check("rs_at_10", 8'h10, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0);
    check("reset_mid_rally", 8'h00, 0, 1, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    check("idle_after_reset", 8'h00, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
